// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and its future transmitter partner.
//   state_t     : frame-level FSM state encoding (3-bit, fixed values so the
//                 encoding stays stable for anything that decodes it).
//   parity_calc : expected parity bit for a data word (even or odd parity).
// ---------------------------------------------------------------------------
package uart_pkg;

    // Widest data word either side of the link supports.
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Returns the parity bit a transmitter would append. Narrower words are
    // zero-extended by the caller, which leaves the XOR reduction unchanged.
    // Even parity: data ^ pbit == 0  ->  pbit = ^data
    // Odd parity : data ^ pbit == 1  ->  pbit = ~^data
    function automatic logic parity_calc(
        input logic [MAX_DATA_BITS-1:0] data,
        input logic                     odd
    );
        return (^data) ^ odd;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Divides the system clock down to the receiver's oversample rate.
// A counter runs 0..CLK_DIV-1 and the tick is high for the single clock in
// which the counter sits at its terminal count.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear; holds the counter at 0 and suppresses tick
//   tick  : one-clock pulse every CLK_DIV clocks while clr is low
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    // A CLK_DIV of 1 still needs a 1-bit counter so the vector is legal;
    // the counter then never leaves 0 and tick fires every clock.
    localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr || (cnt_reg == CNT_LAST)) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign tick = !clr && (cnt_reg == CNT_LAST);

endmodule : uart_baud_tick

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Parametrised oversampling UART receiver with a ready/valid holding register.
// Frame: 1 start bit, DATA_BITS data bits (LSB first), optional parity bit,
// STOP_BITS stop bits. The line is sampled at the centre of each bit: the
// start bit is re-checked half a bit after the falling edge, and every later
// bit is sampled one full bit period after the previous sample.
//
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   ena        : enable; low aborts any frame and parks the FSM in IDLE
//   rx         : asynchronous serial line, idle high
//   data_out   : received word, LSB = first bit on the line
//   valid_out  : data_out and error flags valid; held until accepted
//   ready_in   : consumer accepts the word when valid_out && ready_in
//   parity_err : parity mismatch for the word in data_out
//   frame_err  : some stop bit of the word in data_out was sampled low
//   overrun    : one-clock pulse; a frame finished while the holding
//                register was still full, and that frame was dropped
//   busy       : FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    // ------------------------------------------------------------------
    // Counter sizing. os_cnt only ever reaches OVERSAMPLE-1 and bit_cnt
    // only ever reaches DATA_BITS-1 (stop bits count no higher), so both
    // counters are reset explicitly before they could wrap.
    // ------------------------------------------------------------------
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    localparam int SYNC_STAGES = 2;

    // ------------------------------------------------------------------
    // rx synchroniser. Flops reset to the idle level so leaving reset never
    // looks like a start bit.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Oversample tick. Held in clear while disabled so a re-enabled
    // receiver starts from a known tick phase.
    // ------------------------------------------------------------------
    logic tick;

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!ena),
        .tick  (tick)
    );

    // ------------------------------------------------------------------
    // Frame FSM and datapath
    // ------------------------------------------------------------------
    state_t               state_reg,    state_next;
    logic [OS_W-1:0]      os_cnt_reg,   os_cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg,  bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg,    shift_next;
    logic                 perr_acc_reg, perr_acc_next;
    logic                 ferr_acc_reg, ferr_acc_next;
    logic                 frame_done;

    always_comb begin
        state_next    = state_reg;
        os_cnt_next   = os_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        perr_acc_next = perr_acc_reg;
        ferr_acc_next = ferr_acc_reg;
        frame_done    = 1'b0;

        if (!ena) begin
            // Abandon any partial frame; nothing reaches the holding register.
            state_next   = IDLE;
            os_cnt_next  = '0;
            bit_cnt_next = '0;
        end else if (tick) begin
            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_next    = START;
                        os_cnt_next   = '0;
                        bit_cnt_next  = '0;
                        perr_acc_next = 1'b0;
                        ferr_acc_next = 1'b0;
                    end
                end

                START: begin
                    if (os_cnt_reg == OS_HALF) begin
                        // Mid start bit: still low means a real frame, and this
                        // instant becomes the reference for all later samples.
                        os_cnt_next  = '0;
                        bit_cnt_next = '0;
                        if (!rx_s) begin
                            state_next = DATA;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        os_cnt_next = os_cnt_reg + 1'b1;
                    end
                end

                DATA: begin
                    if (os_cnt_reg == OS_LAST) begin
                        os_cnt_next = '0;
                        // LSB arrives first, so shift in from the top.
                        shift_next  = {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_next = '0;
                            if (PARITY_EN != 0) begin
                                state_next = PARITY;
                            end else begin
                                state_next = STOP;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end else begin
                        os_cnt_next = os_cnt_reg + 1'b1;
                    end
                end

                PARITY: begin
                    if (os_cnt_reg == OS_LAST) begin
                        os_cnt_next   = '0;
                        perr_acc_next = (rx_s != parity_calc(MAX_DATA_BITS'(shift_reg),
                                                             PARITY_ODD != 0));
                        state_next    = STOP;
                    end else begin
                        os_cnt_next = os_cnt_reg + 1'b1;
                    end
                end

                STOP: begin
                    if (os_cnt_reg == OS_LAST) begin
                        os_cnt_next   = '0;
                        // Bad stop bits are only recorded; the frame still runs
                        // to its final stop sample.
                        ferr_acc_next = ferr_acc_reg | ~rx_s;
                        if (bit_cnt_reg == STOP_LAST) begin
                            bit_cnt_next = '0;
                            frame_done   = 1'b1;
                            state_next   = IDLE;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end else begin
                        os_cnt_next = os_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_next   = IDLE;
                    os_cnt_next  = '0;
                    bit_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            os_cnt_reg   <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            perr_acc_reg <= 1'b0;
            ferr_acc_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            os_cnt_reg   <= os_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            perr_acc_reg <= perr_acc_next;
            ferr_acc_reg <= ferr_acc_next;
        end
    end

    // ------------------------------------------------------------------
    // Holding register with ready/valid handshake. A word accepted in the
    // same cycle a frame completes frees the slot for the new word, giving
    // back-to-back valid without a bubble.
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] data_reg,    data_next;
    logic                 valid_reg,   valid_next;
    logic                 perr_reg,    perr_next;
    logic                 ferr_reg,    ferr_next;
    logic                 overrun_reg, overrun_next;
    logic                 accept;

    assign accept = valid_reg && ready_in;

    always_comb begin
        data_next    = data_reg;
        valid_next   = valid_reg;
        perr_next    = perr_reg;
        ferr_next    = ferr_reg;
        overrun_next = 1'b0;

        if (frame_done) begin
            if (!valid_reg || accept) begin
                data_next  = shift_reg;
                perr_next  = perr_acc_reg;
                ferr_next  = ferr_acc_next;
                valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (accept) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
            overrun_reg <= overrun_next;
        end
    end

    assign data_out   = data_reg;
    assign valid_out  = valid_reg;
    assign parity_err = perr_reg;
    assign frame_err  = ferr_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != IDLE);

endmodule : uart_rx_param

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
// Three receivers share clock, reset and enable:
//   u_dut : default 8N1
//   u_par : 8 data bits, even parity, 1 stop bit
//   u_stp : 8 data bits, no parity, 2 stop bits
// Stimulus pushes the expected word into a per-receiver queue; a monitor per
// receiver pops and compares whenever a word is handed over.
// ---------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int BIT_CLKS = 64;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;

    logic       rx_a = 1'b1, ready_a = 1'b1;
    logic [7:0] data_a;
    logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;

    logic       rx_p = 1'b1, ready_p = 1'b1;
    logic [7:0] data_p;
    logic       valid_p, perr_p, ferr_p, ovr_p, busy_p;

    logic       rx_s = 1'b1, ready_s = 1'b1;
    logic [7:0] data_s;
    logic       valid_s, perr_s, ferr_s, ovr_s, busy_s;

    exp_t q_a[$];
    exp_t q_p[$];
    exp_t q_s[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovr_cnt_a = 0;
    int rise_cyc = 0;
    int stop_start_cyc = 0;
    logic valid_a_d = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_rx_param u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx_a),
        .data_out(data_a), .valid_out(valid_a), .ready_in(ready_a),
        .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx_p),
        .data_out(data_p), .valid_out(valid_p), .ready_in(ready_p),
        .parity_err(perr_p), .frame_err(ferr_p), .overrun(ovr_p), .busy(busy_p)
    );

    uart_rx_param #(.STOP_BITS(2)) u_stp (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx_s),
        .data_out(data_s), .valid_out(valid_s), .ready_in(ready_s),
        .parity_err(perr_s), .frame_err(ferr_s), .overrun(ovr_s), .busy(busy_s)
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic sb_compare(input string tag, input exp_t e,
                              input logic [7:0] d, input logic pe, input logic fe);
        checks++;
        if ({d, pe, fe} !== {e.d, e.pe, e.fe}) begin
            errors++;
            $display("FAIL word_%s: got data=%h pe=%b fe=%b expected data=%h pe=%b fe=%b",
                     tag, d, pe, fe, e.d, e.pe, e.fe);
        end else begin
            $display("word_%s data=%h pe=%b fe=%b", tag, d, pe, fe);
        end
    endtask

    task automatic sb_unexpected(input string tag, input logic [7:0] d);
        checks++;
        errors++;
        $display("FAIL unexpected_word_%s: got data=%h expected no word", tag, d);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_n && valid_a && ready_a) begin
            if (q_a.size() == 0) sb_unexpected("a", data_a);
            else sb_compare("a", q_a.pop_front(), data_a, perr_a, ferr_a);
        end
        if (rst_n && ovr_a) ovr_cnt_a++;
        if (valid_a && !valid_a_d) rise_cyc = cyc;
        valid_a_d = valid_a;
    end

    always @(negedge clk) begin
        if (rst_n && valid_p && ready_p) begin
            if (q_p.size() == 0) sb_unexpected("p", data_p);
            else sb_compare("p", q_p.pop_front(), data_p, perr_p, ferr_p);
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid_s && ready_s) begin
            if (q_s.size() == 0) sb_unexpected("s", data_s);
            else sb_compare("s", q_s.pop_front(), data_s, perr_s, ferr_s);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change 1 time unit after the rising edge; monitors sample on the
    // falling edge.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_p = v;
            default: rx_s = v;
        endcase
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit use_par,
                              input bit pbit, input int nstop, input bit s0, input bit s1);
        set_rx(sel, 1'b0);
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, d[i]);
            wait_clks(BIT_CLKS);
        end
        if (use_par) begin
            set_rx(sel, pbit);
            wait_clks(BIT_CLKS);
        end
        stop_start_cyc = cyc;
        set_rx(sel, s0);
        wait_clks(BIT_CLKS);
        if (nstop == 2) begin
            set_rx(sel, s1);
            wait_clks(BIT_CLKS);
        end
        set_rx(sel, 1'b1);
        wait_clks(BIT_CLKS);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int lat;
        int pulse_cyc;

        wait_clks(3);
        chk("reset_data", 32'(data_a), 32'h0);
        chk("reset_valid", 32'(valid_a), 32'h0);
        chk("reset_perr", 32'(perr_a), 32'h0);
        chk("reset_ferr", 32'(ferr_a), 32'h0);
        chk("reset_overrun", 32'(ovr_a), 32'h0);
        chk("reset_busy", 32'(busy_a), 32'h0);
        rst_n = 1'b1;
        wait_clks(10);

        // 8N1 0xA5 and its hand-over latency relative to the stop bit start
        q_a.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        lat = rise_cyc - stop_start_cyc;
        checks++;
        if (lat < 34 || lat > 39) begin
            errors++;
            $display("FAIL valid_latency: got %0d clks after stop start expected 34..39", lat);
        end else begin
            $display("ok   valid_latency: %0d", lat);
        end

        // bad stop bit
        q_a.push_back('{d: 8'h55, pe: 1'b0, fe: 1'b1});
        send_frame(0, 8'h55, 1'b0, 1'b0, 1, 1'b0, 1'b0);

        // even parity: 0x37 has five ones, so the correct parity bit is 1
        q_p.push_back('{d: 8'h37, pe: 1'b1, fe: 1'b0});
        send_frame(1, 8'h37, 1'b1, 1'b0, 1, 1'b1, 1'b0);
        q_p.push_back('{d: 8'h37, pe: 1'b0, fe: 1'b0});
        send_frame(1, 8'h37, 1'b1, 1'b1, 1, 1'b1, 1'b0);

        // two stop bits: clean, then second stop low
        q_s.push_back('{d: 8'h55, pe: 1'b0, fe: 1'b0});
        send_frame(2, 8'h55, 1'b0, 1'b0, 2, 1'b1, 1'b1);
        q_s.push_back('{d: 8'h55, pe: 1'b0, fe: 1'b1});
        send_frame(2, 8'h55, 1'b0, 1'b0, 2, 1'b1, 1'b0);

        // 20-clock glitch: a false start that must not produce a word
        pulse_cyc = cyc;
        rx_a = 1'b0;
        wait_clks(10);
        chk("glitch_busy_high", 32'(busy_a), 32'h1);
        wait_clks(10);
        rx_a = 1'b1;
        wait_clks(pulse_cyc + 40 - cyc);
        chk("glitch_busy_low", 32'(busy_a), 32'h0);
        wait_clks(BIT_CLKS * 2);

        // overrun: hold off the consumer, second frame is dropped
        ready_a = 1'b0;
        q_a.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
        send_frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        chk("overrun_pulses", 32'(ovr_cnt_a), 32'd1);
        chk("held_data", 32'(data_a), 32'h11);
        chk("held_valid", 32'(valid_a), 32'h1);
        ready_a = 1'b1;
        wait_clks(2);
        chk("valid_drop", 32'(valid_a), 32'h0);
        q_a.push_back('{d: 8'h33, pe: 1'b0, fe: 1'b0});
        send_frame(0, 8'h33, 1'b0, 1'b0, 1, 1'b1, 1'b0);

        // ena low in the middle of 0xFF's data bits
        rx_a = 1'b0;
        wait_clks(BIT_CLKS);
        rx_a = 1'b1;
        wait_clks(100);
        ena = 1'b0;
        wait_clks(2);
        chk("ena_abort_busy", 32'(busy_a), 32'h0);
        wait_clks(BIT_CLKS * 10);
        ena = 1'b1;
        wait_clks(BIT_CLKS);
        q_a.push_back('{d: 8'h0F, pe: 1'b0, fe: 1'b0});
        send_frame(0, 8'h0F, 1'b0, 1'b0, 1, 1'b1, 1'b0);

        // asynchronous reset mid-frame with a word held
        ready_a = 1'b0;
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        chk("pre_reset_valid", 32'(valid_a), 32'h1);
        rx_a = 1'b0;
        wait_clks(100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", 32'(data_a), 32'h0);
        chk("async_rst_valid", 32'(valid_a), 32'h0);
        chk("async_rst_ferr", 32'(ferr_a), 32'h0);
        chk("async_rst_busy", 32'(busy_a), 32'h0);
        rx_a = 1'b1;
        ready_a = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(BIT_CLKS);

        chk("queue_a_drained", 32'(q_a.size()), 32'd0);
        chk("queue_p_drained", 32'(q_p.size()), 32'd0);
        chk("queue_s_drained", 32'(q_s.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_param

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the 8N1 UART receiver.
- Configurable data width, oversample rate, parity and stop-bit count, with on-chip baud tick generation.
- Adds a ready/valid output holding register, parity/framing error flags and an overrun indication.
- Sits between the pad-level rx line and the TinyTapeout user logic consuming received bytes.

Parameters:
CLK_DIV, 4, system clocks per oversample tick (>=1)
OVERSAMPLE, 16, oversample ticks per bit period (even, >=4)
DATA_BITS, 8, data bits per frame (5..9)
PARITY_EN, 0, 1 = parity bit present after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
STOP_BITS, 1, stop bits checked (1 or 2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  enable; low aborts frame reception and holds FSM in IDLE
rx  in  1  asynchronous UART line, idle high
data_out  out  DATA_BITS  received data, LSB = first bit on line
valid_out  out  1  data_out/flags valid; held until accepted
ready_in  in  1  consumer accepts when valid_out && ready_in
parity_err  out  1  parity mismatch for word in data_out (0 if PARITY_EN=0)
frame_err  out  1  any stop bit sampled low for word in data_out
overrun  out  1  one-cycle pulse: frame completed while holding register full; new frame dropped
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: data_out=0, valid_out=0, parity_err=0, frame_err=0, overrun=0, busy=0. rx synchroniser flops reset to 1. FSM=IDLE, all counters 0.
- rx passes through a 2-FF synchroniser. All sampling uses the synchronised value (2-clock latency).
- Tick generator: counts 0..CLK_DIV-1 and emits a 1-clock tick at terminal count. Free-runs while ena=1; cleared when ena=0.
- FSM states: IDLE, START, DATA, PARITY, STOP. Oversample counter os_cnt advances on ticks only.
- IDLE: a sampled 0 on a tick -> START, os_cnt=0.
- START: at os_cnt=OVERSAMPLE/2-1, re-sample. If 0 -> DATA with os_cnt=0 and bit_cnt=0 (mid-bit alignment). If 1 -> IDLE (false start; no flag).
- DATA: sample when os_cnt=OVERSAMPLE-1 and shift in LSB first. After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY: sample one bit and compute the error. Even: XOR(data, pbit) must be 0. Odd: must be 1.
- STOP: sample STOP_BITS bits. frame_err = OR of all stop bits sampled 0. There is no early abort on a bad stop bit; framing is checked only.
- Completion at the last stop-bit sample tick. On the next clock:
  - If the holding register is free, or valid_out && ready_in in the completion cycle: load data_out and flags, set valid_out=1.
  - Otherwise keep the old word and flags and pulse overrun for 1 clock.
  - Then return to IDLE; the next start bit is detected from the following tick.
- Latency: valid_out rises 1 clock after the final stop-sample tick.
- Handshake: valid_out falls the cycle after a valid_out && ready_in cycle unless a new word loads in that same edge (simultaneous accept and complete gives back-to-back valid). data_out and flags are stable while valid_out=1.
- ena=0 mid-frame: FSM -> IDLE next clock, partial frame discarded, no flags. The holding register and valid_out are unaffected; handshake still works.
- Line held low (break): frame completes with frame_err=1 and data 0. The FSM waits in IDLE; since rx stays 0 it restarts. This is accepted; no special break detection.
- Bit and oversample counters are sized with $clog2 and never wrap mid-state.

Decomposition:
- Package uart_pkg: state_t enum (IDLE, START, DATA, PARITY, STOP) and function parity_calc(data, odd) returning the expected parity bit. Shared with the future transmitter.
- Sub-module uart_baud_tick (parameter CLK_DIV; ports clk, rst_n, clr, tick) provides the tick generator.

Test Plan:
- Default params, send 8N1 byte 0xA5 with ready_in=1 -> one valid_out pulse, data_out=0xA5, parity_err=0, frame_err=0, valid 1 clock after stop mid-sample (bit period = 64 clks).
- PARITY_EN=1, PARITY_ODD=0: send 0x37 with parity bit 0 (wrong; correct is 1) -> data_out=0x37, parity_err=1. Resend with 1 -> parity_err=0.
- Send 0x55 with stop bit 0 -> frame_err=1, data_out=0x55. With STOP_BITS=2 and second stop 0 -> frame_err=1.
- rx low pulse of 20 clks (< half bit) -> no valid_out, busy returns 0, FSM in IDLE by clock 40.
- ready_in=0, send 0x11 then 0x22 -> data_out stays 0x11, overrun pulses exactly once. Raise ready_in -> valid_out drops. Send 0x33 -> data_out=0x33.
- Deassert ena mid-DATA of 0xFF -> no valid_out. Re-enable and send 0x0F -> data_out=0x0F. Also assert rst_n low mid-frame -> all outputs 0 immediately.
